// File: rtl/etapa_operandos.sv
// rtl/etapa_operandos.sv - RV32I operand-fetch stage: register file, decode and registered output slot
module etapa_operandos (
  input  logic        clk,
  input  logic        reset,
  input  logic        ent_valido,
  output logic        ent_listo,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        esc_hab,
  input  logic [4:0]  esc_rd,
  input  logic [31:0] esc_dato,
  output logic        sal_valido,
  input  logic        sal_listo,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  sel,
  output logic [4:0]  rd,
  output logic        esc_reg,
  output logic        ilegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // Entry 0 is never written, so x0 always reads back as zero.
  logic [31:0] regs_q [32];

  logic        sal_valido_q;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        esc_reg_q, esc_reg_d;
  logic        ilegal_q, ilegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        escribe;
  logic        acepta;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};
  assign shamt = {27'b0, instr[24:20]};

  assign ent_listo = !sal_valido_q || sal_listo;
  assign acepta    = ent_valido && ent_listo;

  // Register reads with write-through bypass so a same-cycle writeback is seen at accept.
  always_comb begin
    rs1_val = 32'b0;
    rs2_val = 32'b0;
    if (rs1_idx != 5'd0) begin
      rs1_val = (esc_hab && esc_rd == rs1_idx) ? esc_dato : regs_q[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      rs2_val = (esc_hab && esc_rd == rs2_idx) ? esc_dato : regs_q[rs2_idx];
    end
  end

  // Decode the incoming instruction into ALU operands and operation select.
  always_comb begin
    a_d      = 32'b0;
    b_d      = 32'b0;
    sel_d    = 4'b0000;
    ilegal_d = 1'b0;
    escribe  = 1'b0;
    rd_d     = instr[11:7];
    unique case (opcode)
      OPC_OP: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        // slt/sltu have no alternate form, so bit 30 is not carried into sel.
        sel_d   = {funct3, (funct3 == 3'b010 || funct3 == 3'b011) ? 1'b0 : instr[30]};
        escribe = 1'b1;
      end
      OPC_OP_IMM: begin
        a_d     = rs1_val;
        b_d     = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
        sel_d   = {funct3, (funct3 == 3'b101) ? instr[30] : 1'b0};
        escribe = 1'b1;
      end
      OPC_LUI: begin
        b_d     = imm_u;
        escribe = 1'b1;
      end
      OPC_AUIPC: begin
        a_d     = pc;
        b_d     = imm_u;
        escribe = 1'b1;
      end
      OPC_LOAD: begin
        a_d     = rs1_val;
        b_d     = imm_i;
        escribe = 1'b1;
      end
      OPC_STORE: begin
        a_d = rs1_val;
        b_d = imm_s;
      end
      default: begin
        ilegal_d = 1'b1;
      end
    endcase
    esc_reg_d = escribe && (rd_d != 5'd0);
  end

  // Register file update; writeback proceeds regardless of output stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'b0;
      end
    end else if (esc_hab && esc_rd != 5'd0) begin
      regs_q[esc_rd] <= esc_dato;
    end
  end

  // Output slot: load on accept, clear on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sal_valido_q <= 1'b0;
      a_q          <= 32'b0;
      b_q          <= 32'b0;
      sel_q        <= 4'b0;
      rd_q         <= 5'b0;
      esc_reg_q    <= 1'b0;
      ilegal_q     <= 1'b0;
    end else if (acepta) begin
      sal_valido_q <= 1'b1;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      rd_q         <= rd_d;
      esc_reg_q    <= esc_reg_d;
      ilegal_q     <= ilegal_d;
    end else if (sal_listo) begin
      sal_valido_q <= 1'b0;
    end
  end

  assign sal_valido = sal_valido_q;
  assign a          = a_q;
  assign b          = b_q;
  assign sel        = sel_q;
  assign rd         = rd_q;
  assign esc_reg    = esc_reg_q;
  assign ilegal     = ilegal_q;

endmodule

// File: tb/tb_etapa_operandos.sv
// tb/tb_etapa_operandos.sv - scoreboard bench for etapa_operandos
module tb_etapa_operandos;

  logic        clk = 1'b0;
  logic        reset;
  logic        ent_valido;
  logic        ent_listo;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        esc_hab;
  logic [4:0]  esc_rd;
  logic [31:0] esc_dato;
  logic        sal_valido;
  logic        sal_listo;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic [4:0]  rd;
  logic        esc_reg;
  logic        ilegal;

  etapa_operandos dut (
    .clk(clk), .reset(reset), .ent_valido(ent_valido), .ent_listo(ent_listo),
    .instr(instr), .pc(pc), .esc_hab(esc_hab), .esc_rd(esc_rd), .esc_dato(esc_dato),
    .sal_valido(sal_valido), .sal_listo(sal_listo), .a(a), .b(b), .sel(sel),
    .rd(rd), .esc_reg(esc_reg), .ilegal(ilegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        esc_reg;
    logic        ilegal;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int          checks = 0;
  int          errors = 0;

  // Reference model: what the ALU should see for an instruction, from the ISA rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
    exp_t        e;
    int          op, f3, rdn;
    logic [31:0] x1, x2, immi, imms, immu;
    bit          writes;
    op   = int'(ins[6:0]);
    f3   = int'(ins[14:12]);
    rdn  = int'(ins[11:7]);
    x1   = mregs[ins[19:15]];
    x2   = mregs[ins[24:20]];
    immi = 32'($signed(ins[31:20]));
    imms = 32'($signed({ins[31:25], ins[11:7]}));
    immu = ins & 32'hFFFF_F000;
    e.a = 0; e.b = 0; e.sel = 0; e.ilegal = 0; e.rd = ins[11:7];
    writes = 1;
    case (op)
      'h33: begin
        e.a = x1; e.b = x2;
        e.sel = 4'(f3 * 2 + ((f3 == 2 || f3 == 3) ? 0 : int'(ins[30])));
      end
      'h13: begin
        e.a = x1;
        e.b = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : immi;
        e.sel = 4'(f3 * 2 + ((f3 == 5) ? int'(ins[30]) : 0));
      end
      'h37: e.b = immu;
      'h17: begin e.a = p; e.b = immu; end
      'h03: begin e.a = x1; e.b = immi; end
      'h23: begin e.a = x1; e.b = imms; writes = 0; end
      default: begin e.ilegal = 1; writes = 0; end
    endcase
    e.esc_reg = writes && rdn != 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Recorder: tracks the register file and pushes the expected result of every accept.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'b0;
    end else begin
      if (esc_hab && esc_rd != 5'd0) mregs[esc_rd] = esc_dato;
      if (ent_valido && ent_listo) sb.push_back(model(instr, pc));
    end
  end

  // Monitor: compares the presented slot against the oldest expectation; pops on transfer.
  always @(negedge clk) begin
    exp_t e;
    int   pend;
    if (!reset) begin
      if (sal_valido) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL slot_unexpected: got sal_valido=1 expected no pending instruction");
        end else begin
          e = sb[0];
          if (a !== e.a || b !== e.b || sel !== e.sel || rd !== e.rd ||
              esc_reg !== e.esc_reg || ilegal !== e.ilegal) begin
            errors++;
            $display("FAIL slot_contents: got a=%08h b=%08h sel=%b rd=%0d esc_reg=%b ilegal=%b expected a=%08h b=%08h sel=%b rd=%0d esc_reg=%b ilegal=%b",
                     a, b, sel, rd, esc_reg, ilegal, e.a, e.b, e.sel, e.rd, e.esc_reg, e.ilegal);
          end
          if (sal_listo) void'(sb.pop_front());
        end
      end else begin
        pend = (ent_valido && ent_listo) ? 1 : 0;
        checks++;
        if (sb.size() > pend) begin
          errors++;
          $display("FAIL slot_dropped: got sal_valido=0 expected %0d pending", sb.size() - pend);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    esc_hab = 1'b1; esc_rd = r; esc_dato = d;
    tick();
    esc_hab = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] p);
    bit acc;
    acc = 0;
    ent_valido = 1'b1; instr = ins; pc = p;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = ent_listo;
      tick();
    end
    ent_valido = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL issue_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {f7, r2, r1, f3, d, op};
  endfunction

  logic [31:0] snap_a, snap_b;
  logic [3:0]  snap_sel;
  logic [6:0]  ops [7];

  initial begin
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h7F};
    reset = 1'b1; ent_valido = 0; instr = 0; pc = 0; esc_hab = 0; esc_rd = 0; esc_dato = 0;
    sal_listo = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset_sal_valido", 32'(sal_valido), 0);
    check("reset_a", a, 0);
    check("reset_b", b, 0);
    check("reset_sel_rd_flags", {sel, rd, esc_reg, ilegal}, 0);
    check("reset_ent_listo", 32'(ent_listo), 1);

    // Plan 1: ADD after writebacks
    write_reg(5'd5, 32'h7);
    write_reg(5'd6, 32'h3);
    issue(32'h006283B3, 32'h0);
    check("add_a", a, 7);
    check("add_b", b, 3);
    check("add_sel", 32'(sel), 0);
    check("add_rd", 32'(rd), 7);
    check("add_esc_reg", 32'(esc_reg), 1);
    check("add_valid", 32'(sal_valido), 1);

    // Plan 2: select encodings
    issue(enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd1, 7'h33), 0);
    check("sub_sel", 32'(sel), 32'b0001);
    issue(32'h4042D113, 0);
    check("srai_sel", 32'(sel), 32'b1011);
    check("srai_b", b, 4);
    issue(enc_r(7'h00, 5'd6, 5'd5, 3'b011, 5'd3, 7'h33), 0);
    check("sltu_sel", 32'(sel), 32'b0110);

    // Plan 3: immediates and PC
    issue({20'h12345, 5'd4, 7'h37}, 0);
    check("lui_a", a, 0);
    check("lui_b", b, 32'h1234_5000);
    issue({20'h00001, 5'd8, 7'h17}, 32'h100);
    check("auipc_a", a, 32'h100);
    check("auipc_b", b, 32'h1000);
    issue(enc_r(7'h7F, 5'd6, 5'd5, 3'b010, 5'h1C, 7'h23), 0);
    check("sw_b", b, 32'hFFFF_FFFC);
    check("sw_esc_reg", 32'(esc_reg), 0);

    // Plan 4: bypass and x0
    esc_hab = 1'b1; esc_rd = 5'd9; esc_dato = 32'hDEAD_BEEF;
    issue({12'h000, 5'd9, 3'b000, 5'd10, 7'h13}, 0);
    esc_hab = 1'b0;
    check("bypass_a", a, 32'hDEAD_BEEF);
    write_reg(5'd0, 32'h5);
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd11, 7'h33), 0);
    check("x0_a", a, 0);
    check("x0_b", b, 0);

    // Plan 5: backpressure
    issue({12'h001, 5'd5, 3'b000, 5'd12, 7'h13}, 0);
    sal_listo = 1'b0;
    ent_valido = 1'b1; instr = enc_r(7'h00, 5'd6, 5'd5, 3'b100, 5'd13, 7'h33);
    snap_a = a; snap_b = b; snap_sel = sel;
    for (int n = 0; n < 3; n++) begin
      esc_hab = 1'b1; esc_rd = 5'd5; esc_dato = 32'h55 + n;
      @(negedge clk);
      check("stall_ent_listo", 32'(ent_listo), 0);
      check("stall_a", a, snap_a);
      check("stall_b_sel", {b[27:0], snap_sel}, {snap_b[27:0], sel});
      tick();
    end
    esc_hab = 1'b0;
    sal_listo = 1'b1;
    @(negedge clk);
    check("release_ent_listo", 32'(ent_listo), 1);
    tick();
    ent_valido = 1'b0;
    check("release_valid", 32'(sal_valido), 1);
    check("release_rd", 32'(rd), 13);
    check("release_a", a, 32'h57);
    issue({25'h1ABCDE, 7'h7F}, 0);
    check("illegal_flag", 32'(ilegal), 1);
    check("illegal_esc_reg", 32'(esc_reg), 0);

    // Plan 6: reset while stalled
    issue({12'h000, 5'd5, 3'b000, 5'd14, 7'h13}, 0);
    sal_listo = 1'b0;
    tick();
    reset = 1'b1; ent_valido = 1'b1; instr = 32'h006283B3;
    esc_hab = 1'b1; esc_rd = 5'd3; esc_dato = 32'h1234;
    tick();
    reset = 1'b0; ent_valido = 1'b0; esc_hab = 1'b0; sal_listo = 1'b1;
    check("reset_stall_valid", 32'(sal_valido), 0);
    issue(enc_r(7'h00, 5'd3, 5'd5, 3'b000, 5'd7, 7'h33), 0);
    check("reset_x5", a, 0);
    check("reset_x3_ignored", b, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      sal_listo  = ($urandom_range(0, 3) != 0);
      ent_valido = ($urandom_range(0, 2) != 0);
      instr      = {$urandom() >> 7, ops[$urandom_range(0, 6)]};
      pc         = $urandom();
      esc_hab    = ($urandom_range(0, 1) == 1);
      esc_rd     = 5'($urandom_range(0, 31));
      esc_dato   = $urandom();
      tick();
    end
    ent_valido = 1'b0; esc_hab = 1'b0; sal_listo = 1'b1;
    tick(); tick();
    check("drain_empty", sb.size(), 0);
    check("drain_valid", 32'(sal_valido), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
